// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time and
// presents {pc, inst} to decode through a one-entry valid/ready output register.
module inst_fetch #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h1C000000
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic                  imem_rvalid,
   input  logic [INST_WIDTH-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   input  logic                  id_ready,
   output logic                  if_valid,
   output logic [ADDR_WIDTH-1:0] if_pc,
   output logic [INST_WIDTH-1:0] if_inst,
   output logic                  if_excp_adef
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] pc, pc_n;
   logic [ADDR_WIDTH-1:0] req_pc, req_pc_n;
   logic                  drop, drop_n;
   logic                  valid_n;
   logic [ADDR_WIDTH-1:0] if_pc_n;
   logic [INST_WIDTH-1:0] if_inst_n;
   logic                  adef_n;
   logic                  aligned;
   logic                  accept;

   assign aligned   = (pc[1:0] == 2'b00);
   assign imem_req  = !rst && (state == S_REQ) && aligned;
   assign imem_addr = pc;
   assign accept    = imem_req && imem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_REQ;
         pc           <= RESET_PC;
         req_pc       <= RESET_PC;
         drop         <= 1'b0;
         if_valid     <= 1'b0;
         if_pc        <= RESET_PC;
         if_inst      <= '0;
         if_excp_adef <= 1'b0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         req_pc       <= req_pc_n;
         drop         <= drop_n;
         if_valid     <= valid_n;
         if_pc        <= if_pc_n;
         if_inst      <= if_inst_n;
         if_excp_adef <= adef_n;
      end
   end

   // drop marks a request already accepted by memory whose response must be
   // thrown away because a redirect arrived after it was issued.
   always_comb begin
      state_n   = state;
      pc_n      = pc;
      req_pc_n  = req_pc;
      drop_n    = drop;
      valid_n   = if_valid;
      if_pc_n   = if_pc;
      if_inst_n = if_inst;
      adef_n    = if_excp_adef;

      case (state)
         S_REQ: begin
            if (!aligned) begin
               if (!redirect_valid) begin
                  state_n   = S_HOLD;
                  valid_n   = 1'b1;
                  if_pc_n   = pc;
                  if_inst_n = '0;
                  adef_n    = 1'b1;
               end
            end else if (accept) begin
               state_n  = S_WAIT;
               req_pc_n = pc;
               drop_n   = redirect_valid;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               drop_n = 1'b0;
               if (!drop && !redirect_valid) begin
                  state_n   = S_HOLD;
                  valid_n   = 1'b1;
                  if_pc_n   = req_pc;
                  if_inst_n = imem_rdata;
                  adef_n    = 1'b0;
               end else begin
                  state_n = S_REQ;
               end
            end else if (redirect_valid) begin
               drop_n = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect_valid || (if_valid && id_ready)) begin
               valid_n = 1'b0;
               state_n = S_REQ;
               pc_n    = pc + ADDR_WIDTH'(4);
            end
         end
         default: state_n = S_REQ;
      endcase

      // A taken branch always wins over sequential advance.
      if (redirect_valid)
         pc_n = redirect_target;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage. Owns the PC, issues word fetches to the instruction memory port, and hands {pc, inst} to instruction decode over a valid/ready handshake. It accepts branch/jump redirects from the decode/branch path and discards in-flight stale responses. Misaligned PCs produce an ADEF flag instead of a memory request.

Parameters:
ADDR_WIDTH, 32, PC and memory address width
INST_WIDTH, 32, instruction word width
RESET_PC, 32'h1C000000, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_WIDTH  fetch address; equals pc register
imem_ready  in  1  memory accepts request this cycle when imem_req && imem_ready
imem_rvalid  in  1  response valid; one-cycle pulse
imem_rdata  in  INST_WIDTH  response instruction word
redirect_valid  in  1  branch/jump taken, one-cycle pulse
redirect_target  in  ADDR_WIDTH  new PC
id_ready  in  1  decode accepts the current instruction
if_valid  out  1  if_pc/if_inst/if_excp_adef valid
if_pc  out  ADDR_WIDTH  PC of delivered instruction
if_inst  out  INST_WIDTH  delivered instruction (0 when ADEF)
if_excp_adef  out  1  fetch address error (pc[1:0] != 0)

Behaviour:
- Reset (async, rst=1): state=S_REQ, pc=RESET_PC, drop=0, if_valid=0, if_pc=RESET_PC, if_inst=0, if_excp_adef=0. imem_req forced 0 while rst=1.
- At most one outstanding memory request. A one-entry output register holds the delivered instruction.
- S_REQ:
  - imem_req = (pc[1:0]==0); imem_addr = pc.
  - If misaligned: no request. Next cycle enter S_HOLD with if_valid=1, if_pc=pc, if_inst=0, if_excp_adef=1.
  - If aligned and imem_ready=1: go S_WAIT and latch req_pc=pc.
- S_WAIT:
  - imem_req=0.
  - On imem_rvalid with drop=0: next cycle enter S_HOLD with if_valid=1, if_pc=req_pc, if_inst=imem_rdata, if_excp_adef=0.
  - On imem_rvalid with drop=1: discard the response, clear drop, go S_REQ.
  - imem_rvalid is ignored in every other state.
- S_HOLD:
  - Outputs are stable while if_valid && !id_ready.
  - On the handshake (if_valid && id_ready): pc <= pc+4 (mod 2^ADDR_WIDTH wrap), if_valid <= 0, go S_REQ.
- Redirect has priority over pc+4 in every state; pc <= redirect_target.
  - S_REQ, no acceptance: stay S_REQ; imem_addr shows the target next cycle. Memory samples the address only on acceptance.
  - S_REQ with acceptance in the same cycle: go S_WAIT with drop=1.
  - S_WAIT, no rvalid: drop <= 1, stay S_WAIT.
  - S_WAIT with rvalid in the same cycle: discard the response, drop stays 0, go S_REQ.
  - S_HOLD: if_valid <= 0, go S_REQ. If the handshake fires the same cycle, the instruction counts as consumed; pc still takes redirect_target.
- Latency:
  - Request acceptance to if_valid = response latency + 1 cycle.
  - Handshake to next imem_req = 1 cycle.
- A misaligned redirect target yields repeated ADEF deliveries at pc, pc+4, ... until the commit path redirects.

Test Plan:
- Reset release; imem_ready=1, rvalid one cycle after each acceptance, rdata=addr^32'hFFFF0000, id_ready=1 -> requests at 0x1C000000, 0x1C000004, 0x1C000008; if_pc/if_inst match in order; no duplicates or gaps.
- Hold id_ready=0 for 5 cycles in S_HOLD -> if_valid=1, if_pc/if_inst constant, imem_req=0 throughout; after id_ready=1, next request at if_pc+4.
- Redirect to 0x1C000100 while waiting for the response of 0x1C000004 -> that response is discarded (never appears on if_*); next request is at 0x1C000100; next delivered if_pc=0x1C000100.
- Redirect coinciding with imem_rvalid in S_WAIT, and separately with acceptance in S_REQ (target 0x1C000200) -> stale word dropped; delivered if_pc=0x1C000200; exactly one response consumed per request.
- Redirect to 0x1C000102 -> no imem_req; if_valid=1, if_pc=0x1C000102, if_inst=0, if_excp_adef=1; after handshake, the next delivery is 0x1C000106 with adef=1.
- Assert rst in S_WAIT with a late imem_rvalid arriving after reset release while in S_REQ -> all outputs at reset values; late response ignored; first request at 0x1C000000.
